regfile_writeback_queue: RTL

//  Write side of the register file: collects results from the ALU and the load unit, queues them in order and drains them one per cycle onto the register file's single write port.

---
 rtl/regfile_writeback_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regfile_writeback_queue.sv
// Register-file write-back queue: merges load and ALU results in order and drains one per cycle.
// Pending entries are forwarded to two read selectors, and the youngest match wins.

module regfile_writeback_queue_fwd #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32,
  parameter int SEL_W  = 5
) (
  input  logic [DEPTH-1:0]             occ,
  input  logic [DEPTH-1:0][SEL_W-1:0]  sels,
  input  logic [DEPTH-1:0][WORD_W-1:0] dats,
  input  logic [SEL_W-1:0]             sel,
  output logic                         hit,
  output logic [WORD_W-1:0]            dat
);
  // Entries are in age order (0 = head), so the last match is the youngest.
  always_comb begin
    hit = 1'b0;
    dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && sels[i] == sel && sel != '0) begin
        hit = 1'b1;
        dat = dats[i];
      end
    end
  end
endmodule

module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32,
  parameter int SEL_W  = 5
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [SEL_W-1:0]           mem_sel,
  input  logic [WORD_W-1:0]          mem_dat,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [SEL_W-1:0]           alu_sel,
  input  logic [WORD_W-1:0]          alu_dat,
  output logic                       rf_wen,
  output logic [SEL_W-1:0]           rf_wsel,
  output logic [WORD_W-1:0]          rf_wdat,
  input  logic [SEL_W-1:0]           fwd_sel1,
  output logic                       fwd_hit1,
  output logic [WORD_W-1:0]          fwd_dat1,
  input  logic [SEL_W-1:0]           fwd_sel2,
  output logic                       fwd_hit2,
  output logic [WORD_W-1:0]          fwd_dat2,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NP = 2;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [WORD_W-1:0] dat;
  } entry_t;

  entry_t [DEPTH-1:0] ent;
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW:0]        free;
  logic               pop, mem_keep, alu_keep;
  entry_t             head;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = !empty;
  // Head slot frees on this edge, so it counts as free whenever occupied.
  assign free  = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
  assign mem_ready = (free >= (CW+1)'(1));
  assign alu_ready = (free >= (CW+1)'(2));

  // x0 pushes handshake normally but never occupy a slot.
  assign mem_keep = mem_valid && mem_ready && (mem_sel != '0);
  assign alu_keep = alu_valid && alu_ready && (alu_sel != '0);

  assign head    = ent[rd_ptr];
  assign rf_wen  = !empty;
  assign rf_wsel = empty ? '0 : head.sel;
  assign rf_wdat = empty ? '0 : head.dat;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (mem_keep) ent[wr_ptr] <= '{sel: mem_sel, dat: mem_dat};
      if (alu_keep) ent[wr_ptr + PW'(mem_keep)] <= '{sel: alu_sel, dat: alu_dat};
      wr_ptr <= wr_ptr + PW'(mem_keep) + PW'(alu_keep);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(mem_keep) + CW'(alu_keep) - CW'(pop);
    end
  end

  // Age-ordered view of the ring for the forwarding lanes.
  logic [DEPTH-1:0]             occ;
  logic [DEPTH-1:0][SEL_W-1:0]  ord_sel;
  logic [DEPTH-1:0][WORD_W-1:0] ord_dat;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ord
    assign occ[i]     = (CW'(i) < count);
    assign ord_sel[i] = ent[rd_ptr + PW'(i)].sel;
    assign ord_dat[i] = ent[rd_ptr + PW'(i)].dat;
  end

  logic [NP-1:0][SEL_W-1:0]  fsel;
  logic [NP-1:0]             fhit;
  logic [NP-1:0][WORD_W-1:0] fdat;

  assign fsel = {fwd_sel2, fwd_sel1};

  regfile_writeback_queue_fwd #(
    .DEPTH(DEPTH), .WORD_W(WORD_W), .SEL_W(SEL_W)
  ) u_fwd [NP-1:0] (
    .occ (occ),
    .sels(ord_sel),
    .dats(ord_dat),
    .sel (fsel),
    .hit (fhit),
    .dat (fdat)
  );

  assign fwd_hit1 = fhit[0];
  assign fwd_dat1 = fdat[0];
  assign fwd_hit2 = fhit[1];
  assign fwd_dat2 = fdat[1];
endmodule
